// File: rtl/keypad_emulator.sv
// Emulated 4x4 switch matrix: presses one requested key for HOLD_CYCLES, then
// guarantees RELEASE_CYCLES of all-released gap before taking the next request.
module keypad_emulator #(
  parameter int HOLD_CYCLES    = 1_000_000,
  parameter int RELEASE_CYCLES = 500_000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_req,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE, REJECT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cur_key_q, cur_key_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_key_d = cur_key_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_key_d = key_req[3:0];
          cnt_d     = '0;
          if (key_req[4]) begin
            state_d = REJECT;
            err_d   = 1'b1;
          end else begin
            state_d = PRESS;
          end
        end
      end
      PRESS: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == REL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_key_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_key_q <= cur_key_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Closed switch: the target column follows its row drive with no clock in the path.
  always_comb begin
    columna = 4'b1111;
    if (state_q == PRESS) columna[cur_key_q[1:0]] = fila[cur_key_q[3:2]];
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == PRESS) || (state_q == RELEASE);
  assign done      = done_q;
  assign err       = err_q;

endmodule
